// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module : data_bus_responder
// Desc   : Data-memory bus responder: word RAM plus a 32-byte MMIO window
//          (console TX FIFO, status, 64-bit cycle counter, tohost).
// Rev    : 1.0 - initial release
// ============================================================================
module data_bus_responder #(
    parameter int unsigned RAM_WORDS  = 4096,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] MMIO_BASE  = 32'h1000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] mem_addr,
    input  logic        mem_r_enable,
    input  logic        mem_w_enable,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tohost_valid,
    output logic [31:0] tohost_data,
    output logic        bus_err
);

    localparam int unsigned     c_AW          = $clog2(RAM_WORDS);
    localparam int unsigned     c_PW          = $clog2(FIFO_DEPTH);
    localparam int unsigned     c_LW          = c_PW + 1;
    localparam logic [c_LW-1:0] c_FULL_LEVEL  = c_LW'(FIFO_DEPTH);
    localparam logic [2:0]      c_OFF_CONSOLE = 3'd0;
    localparam logic [2:0]      c_OFF_STATUS  = 3'd1;
    localparam logic [2:0]      c_OFF_CYC_LO  = 3'd2;
    localparam logic [2:0]      c_OFF_CYC_HI  = 3'd3;
    localparam logic [2:0]      c_OFF_TOHOST  = 3'd4;

    // Storage arrays (not reset)
    logic [31:0]     r_ram [RAM_WORDS];
    logic [31:0]     r_ram_rdata_q;
    logic [7:0]      r_fifo [FIFO_DEPTH];

    // Control state
    logic            r_rd_ram_q,       w_rd_ram_d;
    logic [31:0]     r_mmio_rdata_q,   w_mmio_rdata_d;
    logic [c_PW-1:0] r_wr_ptr_q,       w_wr_ptr_d;
    logic [c_PW-1:0] r_rd_ptr_q,       w_rd_ptr_d;
    logic [c_LW-1:0] r_level_q,        w_level_d;
    logic            r_overflow_q,     w_overflow_d;
    logic [63:0]     r_cycle_q,        w_cycle_d;
    logic [31:0]     r_tohost_data_q,  w_tohost_data_d;
    logic            r_tohost_valid_q, w_tohost_valid_d;
    logic            r_bus_err_q,      w_bus_err_d;

    // Decode
    logic            w_ram_hit;
    logic            w_mmio_hit;
    logic            w_unmapped;
    logic [c_AW-1:0] w_ram_idx;
    logic [2:0]      w_off;
    logic            w_mmio_wr;
    logic            w_push_req;
    logic            w_push_ok;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [7:0]      w_level8;
    logic [31:0]     w_status;
    logic [31:0]     w_mmio_rval;
    logic            w_unused_addr_bits;

    assign w_ram_hit          = (mem_addr[31:c_AW+2] == '0);
    assign w_mmio_hit         = (mem_addr[31:5] == MMIO_BASE[31:5]);
    assign w_unmapped         = !w_ram_hit && !w_mmio_hit;
    assign w_ram_idx          = mem_addr[c_AW+1:2];
    assign w_off              = mem_addr[4:2];
    assign w_unused_addr_bits = ^mem_addr[1:0];

    assign w_mmio_wr  = mem_w_enable && w_mmio_hit;
    assign w_push_req = w_mmio_wr && (w_off == c_OFF_CONSOLE);
    assign w_empty    = (r_level_q == '0);
    assign w_full     = (r_level_q == c_FULL_LEVEL);
    assign w_pop      = !w_empty && tx_ready;
    // A push into a full FIFO still lands if the head leaves at the same edge
    assign w_push_ok  = w_push_req && (!w_full || w_pop);
    assign w_level8   = 8'(r_level_q);
    assign w_status   = {16'd0, w_level8, 5'd0, r_overflow_q, w_full, w_empty};

    always_comb begin
        w_mmio_rval = 32'd0;
        case (w_off)
            c_OFF_STATUS: w_mmio_rval = w_status;
            c_OFF_CYC_LO: w_mmio_rval = r_cycle_q[31:0];
            c_OFF_CYC_HI: w_mmio_rval = r_cycle_q[63:32];
            c_OFF_TOHOST: w_mmio_rval = r_tohost_data_q;
            default:      w_mmio_rval = 32'd0;
        endcase
    end

    always_comb begin
        w_rd_ram_d       = r_rd_ram_q;
        w_mmio_rdata_d   = r_mmio_rdata_q;
        w_wr_ptr_d       = r_wr_ptr_q;
        w_rd_ptr_d       = r_rd_ptr_q;
        w_level_d        = r_level_q;
        w_overflow_d     = r_overflow_q;
        w_cycle_d        = r_cycle_q + 64'd1;
        w_tohost_data_d  = r_tohost_data_q;
        w_tohost_valid_d = 1'b0;
        w_bus_err_d      = r_bus_err_q;

        if (mem_r_enable) begin
            w_rd_ram_d     = w_ram_hit;
            w_mmio_rdata_d = w_mmio_hit ? w_mmio_rval : 32'd0;
        end

        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PW'(1);
        end
        if (w_push_ok) begin
            w_wr_ptr_d = r_wr_ptr_q + c_PW'(1);
        end
        if (w_push_ok && !w_pop) begin
            w_level_d = r_level_q + c_LW'(1);
        end else if (!w_push_ok && w_pop) begin
            w_level_d = r_level_q - c_LW'(1);
        end

        if (w_push_req && !w_push_ok) begin
            w_overflow_d = 1'b1;
        end
        if (w_mmio_wr && (w_off == c_OFF_STATUS) && mem_wdata[2]) begin
            w_overflow_d = 1'b0;
        end

        if (w_mmio_wr && (w_off == c_OFF_TOHOST)) begin
            w_tohost_data_d  = mem_wdata;
            w_tohost_valid_d = 1'b1;
        end

        if (mem_w_enable && w_unmapped) begin
            w_bus_err_d = 1'b1;
        end
    end

    // Read-before-write falls out of the non-blocking read in the same block
    always_ff @(posedge clk) begin
        if (mem_w_enable && w_ram_hit) begin
            r_ram[w_ram_idx] <= mem_wdata;
        end
        if (mem_r_enable && w_ram_hit) begin
            r_ram_rdata_q <= r_ram[w_ram_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr_q] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_ram_q       <= 1'b0;
            r_mmio_rdata_q   <= 32'd0;
            r_wr_ptr_q       <= '0;
            r_rd_ptr_q       <= '0;
            r_level_q        <= '0;
            r_overflow_q     <= 1'b0;
            r_cycle_q        <= 64'd0;
            r_tohost_data_q  <= 32'd0;
            r_tohost_valid_q <= 1'b0;
            r_bus_err_q      <= 1'b0;
        end else begin
            r_rd_ram_q       <= w_rd_ram_d;
            r_mmio_rdata_q   <= w_mmio_rdata_d;
            r_wr_ptr_q       <= w_wr_ptr_d;
            r_rd_ptr_q       <= w_rd_ptr_d;
            r_level_q        <= w_level_d;
            r_overflow_q     <= w_overflow_d;
            r_cycle_q        <= w_cycle_d;
            r_tohost_data_q  <= w_tohost_data_d;
            r_tohost_valid_q <= w_tohost_valid_d;
            r_bus_err_q      <= w_bus_err_d;
        end
    end

    assign mem_rdata    = r_rd_ram_q ? r_ram_rdata_q : r_mmio_rdata_q;
    assign tx_valid     = !w_empty;
    assign tx_data      = r_fifo[r_rd_ptr_q];
    assign tohost_valid = r_tohost_valid_q;
    assign tohost_data  = r_tohost_data_q;
    assign bus_err      = r_bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_bus_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_data_bus_responder
// Desc   : Self-checking bench for data_bus_responder: vector table, corner
//          sequences and random traffic against a queue-based model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_data_bus_responder;

    localparam int unsigned RAM_WORDS  = 4096;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam logic [31:0] MMIO_BASE  = 32'h1000_0000;
    localparam logic [31:0] c_CTX      = MMIO_BASE;
    localparam logic [31:0] c_STAT     = MMIO_BASE + 32'h04;
    localparam logic [31:0] c_CLO      = MMIO_BASE + 32'h08;
    localparam logic [31:0] c_CHI      = MMIO_BASE + 32'h0C;
    localparam logic [31:0] c_TOHOST   = MMIO_BASE + 32'h10;
    localparam logic [31:0] c_UNMAP    = 32'h2000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic        mem_r_enable = 1'b0;
    logic        mem_w_enable = 1'b0;
    logic [31:0] mem_wdata = 32'd0;
    logic        tx_ready = 1'b0;
    logic [31:0] mem_rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        bus_err;

    int n_checks = 0;
    int n_errors = 0;

    data_bus_responder #(
        .RAM_WORDS (RAM_WORDS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .MMIO_BASE (MMIO_BASE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mem_addr    (mem_addr),
        .mem_r_enable(mem_r_enable),
        .mem_w_enable(mem_w_enable),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tohost_valid(tohost_valid),
        .tohost_data (tohost_data),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    // Reference model: memory map behaviour in terms of a byte queue
    logic [31:0] m_ram [int unsigned];
    logic [7:0]  m_q[$];
    bit          m_ovf = 1'b0;
    bit          m_berr = 1'b0;
    bit          m_thv = 1'b0;
    logic [31:0] m_thd = 32'd0;
    logic [31:0] m_rd = 32'd0;
    longint unsigned m_cyc = 0;

    function automatic logic [31:0] model_status();
        int lvl = m_q.size();
        return 32'(lvl * 256 + (m_ovf ? 4 : 0) + ((lvl == int'(FIFO_DEPTH)) ? 2 : 0) + ((lvl == 0) ? 1 : 0));
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int off;
        if (a < RAM_WORDS * 4) return m_ram.exists(a >> 2) ? m_ram[a >> 2] : 32'd0;
        if ((a >> 5) != (MMIO_BASE >> 5)) return 32'd0;
        off = int'((a >> 2) & 32'd7);
        case (off)
            1:       return model_status();
            2:       return m_cyc[31:0];
            3:       return m_cyc[63:32];
            4:       return m_thd;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge();
        logic [31:0] a;
        int off;
        if (!reset_n) begin
            m_q.delete();
            m_ovf = 0; m_berr = 0; m_thv = 0; m_thd = 32'd0; m_rd = 32'd0; m_cyc = 0;
            return;
        end
        a   = mem_addr;
        off = int'((a >> 2) & 32'd7);
        m_thv = 0;
        if (mem_r_enable) m_rd = model_read(a);
        if (tx_ready && m_q.size() > 0) void'(m_q.pop_front());
        if (mem_w_enable) begin
            if (a < RAM_WORDS * 4) begin
                m_ram[a >> 2] = mem_wdata;
            end else if ((a >> 5) == (MMIO_BASE >> 5)) begin
                if (off == 0) begin
                    if (m_q.size() < int'(FIFO_DEPTH)) m_q.push_back(mem_wdata[7:0]);
                    else m_ovf = 1;
                end else if (off == 1 && mem_wdata[2]) begin
                    m_ovf = 0;
                end else if (off == 4) begin
                    m_thd = mem_wdata;
                    m_thv = 1;
                end
            end else begin
                m_berr = 1;
            end
        end
        m_cyc++;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit rn, input logic [31:0] a, input bit r, input bit w,
                        input logic [31:0] d, input bit rdy);
        reset_n = rn; mem_addr = a; mem_r_enable = r; mem_w_enable = w;
        mem_wdata = d; tx_ready = rdy;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    typedef struct {
        string       name;
        bit          rn;
        logic [31:0] a;
        bit          r;
        bit          w;
        logic [31:0] d;
        bit          rdy;
        logic [31:0] e_rd;
        bit          e_txv;
        logic [7:0]  e_txd;
        bit          e_thv;
        logic [31:0] e_thd;
        bit          e_berr;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input string name, input bit rn, input logic [31:0] a, input bit r,
                       input bit w, input logic [31:0] d, input logic [31:0] e_rd,
                       input bit e_txv, input logic [7:0] e_txd, input bit e_thv,
                       input logic [31:0] e_thd, input bit e_berr);
        vec_t v;
        v.name = name; v.rn = rn; v.a = a; v.r = r; v.w = w; v.d = d; v.rdy = 1'b0;
        v.e_rd = e_rd; v.e_txv = e_txv; v.e_txd = e_txd; v.e_thv = e_thv;
        v.e_thd = e_thd; v.e_berr = e_berr;
        tbl.push_back(v);
    endtask

    logic [7:0] exp_bytes[$];

    task automatic drain(input string name);
        logic [7:0] got[$];
        int guard = 0;
        while (tx_valid && guard < 4 * int'(FIFO_DEPTH)) begin
            got.push_back(tx_data);
            step(1, 32'd0, 0, 0, 32'd0, 1);
            guard++;
        end
        chk({name, "_emptied"}, 64'(tx_valid), 64'd0);
        chk({name, "_count"}, 64'(got.size()), 64'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size() && i < got.size(); i++)
            chk({name, "_byte"}, 64'(got[i]), 64'(exp_bytes[i]));
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned k = $urandom_range(0, 9);
        int unsigned w;
        if (k < 4) begin
            w = $urandom_range(0, 16);
            if (w == 16) w = RAM_WORDS - 1;
            return 32'(w * 4 + $urandom_range(0, 3));
        end
        if (k < 6) return c_CTX + 32'($urandom_range(0, 3));
        if (k < 8) return MMIO_BASE + 32'($urandom_range(1, 7) * 4 + $urandom_range(0, 3));
        if (k == 8) return c_UNMAP + 32'($urandom_range(0, 255) * 4);
        return 32'(RAM_WORDS * 4 + $urandom_range(0, 3) * 4);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        bit rn, r, w, rdy;
        logic [31:0] a;

        // ---------------- directed vector table ----------------
        add("reset",          0, 32'd0,           0, 0, 32'd0,          32'd0,          0, 8'h00, 0, 32'd0, 0);
        add("ram_wr",         1, 32'h10,          0, 1, 32'hDEADBEEF,   32'd0,          0, 8'h00, 0, 32'd0, 0);
        add("ram_rd_unalign", 1, 32'h13,          1, 0, 32'd0,          32'hDEADBEEF,   0, 8'h00, 0, 32'd0, 0);
        add("rw_same_edge",   1, 32'h10,          1, 1, 32'h1,          32'hDEADBEEF,   0, 8'h00, 0, 32'd0, 0);
        add("ram_rd_new",     1, 32'h10,          1, 0, 32'd0,          32'h1,          0, 8'h00, 0, 32'd0, 0);
        add("rdata_hold",     1, c_UNMAP,         0, 0, 32'd0,          32'h1,          0, 8'h00, 0, 32'd0, 0);
        add("ram_top_wr",     1, 32'h3FFC,        0, 1, 32'hCAFEF00D,   32'h1,          0, 8'h00, 0, 32'd0, 0);
        add("ram_top_rd",     1, 32'h3FFC,        1, 0, 32'd0,          32'hCAFEF00D,   0, 8'h00, 0, 32'd0, 0);
        add("reserved_wr",    1, MMIO_BASE+32'h14,0, 1, 32'hFFFFFFFF,   32'hCAFEF00D,   0, 8'h00, 0, 32'd0, 0);
        add("reserved_rd",    1, MMIO_BASE+32'h1C,1, 0, 32'd0,          32'd0,          0, 8'h00, 0, 32'd0, 0);
        add("tohost_wr",      1, c_TOHOST,        0, 1, 32'h1,          32'd0,          0, 8'h00, 1, 32'h1, 0);
        add("tohost_pulse",   1, c_TOHOST,        0, 0, 32'd0,          32'd0,          0, 8'h00, 0, 32'h1, 0);
        add("tohost_rd",      1, c_TOHOST,        1, 0, 32'd0,          32'h1,          0, 8'h00, 0, 32'h1, 0);
        add("past_ram_rd",    1, 32'h4000,        1, 0, 32'd0,          32'd0,          0, 8'h00, 0, 32'h1, 0);
        add("unmapped_wr",    1, c_UNMAP,         0, 1, 32'h5,          32'd0,          0, 8'h00, 0, 32'h1, 1);
        add("unmapped_rd",    1, c_UNMAP,         1, 0, 32'd0,          32'd0,          0, 8'h00, 0, 32'h1, 1);
        add("berr_sticky",    1, 32'd0,           0, 0, 32'd0,          32'd0,          0, 8'h00, 0, 32'h1, 1);
        add("console_rd",     1, c_CTX,           1, 0, 32'd0,          32'd0,          0, 8'h00, 0, 32'h1, 1);
        for (int i = 0; i < 9; i++)
            add("console_push", 1, c_CTX, 0, 1, 32'(8'h41 + i), 32'd0, 1, 8'h41, 0, 32'h1, 1);
        add("status_full",    1, c_STAT,          1, 0, 32'd0,          32'h0000_0806,  1, 8'h41, 0, 32'h1, 1);
        add("status_again",   1, c_STAT,          1, 0, 32'd0,          32'h0000_0806,  1, 8'h41, 0, 32'h1, 1);

        foreach (tbl[i]) begin
            step(tbl[i].rn, tbl[i].a, tbl[i].r, tbl[i].w, tbl[i].d, tbl[i].rdy);
            chk({tbl[i].name, "_rdata"}, 64'(mem_rdata), 64'(tbl[i].e_rd));
            chk({tbl[i].name, "_txv"}, 64'(tx_valid), 64'(tbl[i].e_txv));
            if (tbl[i].e_txv) chk({tbl[i].name, "_txd"}, 64'(tx_data), 64'(tbl[i].e_txd));
            chk({tbl[i].name, "_thv"}, 64'(tohost_valid), 64'(tbl[i].e_thv));
            chk({tbl[i].name, "_thd"}, 64'(tohost_data), 64'(tbl[i].e_thd));
            chk({tbl[i].name, "_berr"}, 64'(bus_err), 64'(tbl[i].e_berr));
        end

        // ---------------- drain after overflow ----------------
        exp_bytes.delete();
        for (int i = 0; i < 8; i++) exp_bytes.push_back(8'(8'h41 + i));
        drain("drain_41");
        step(1, c_STAT, 1, 0, 32'd0, 0);
        chk("status_drained", 64'(mem_rdata), 64'h5);
        step(1, c_STAT, 0, 1, 32'h4, 0);
        step(1, c_STAT, 1, 0, 32'd0, 0);
        chk("status_ovf_clr", 64'(mem_rdata), 64'h1);

        // ---------------- push into full FIFO while popping ----------------
        for (int i = 0; i < 8; i++) step(1, c_CTX, 0, 1, 32'(8'h61 + i), 0);
        step(1, c_CTX, 0, 1, 32'h5A, 1);
        chk("fullpush_txv", 64'(tx_valid), 64'd1);
        chk("fullpush_txd", 64'(tx_data), 64'h62);
        step(1, c_STAT, 1, 0, 32'd0, 0);
        chk("fullpush_status", 64'(mem_rdata), 64'h0802);
        exp_bytes.delete();
        for (int i = 1; i < 8; i++) exp_bytes.push_back(8'(8'h61 + i));
        exp_bytes.push_back(8'h5A);
        drain("drain_5a");

        // ---------------- reset with bytes queued ----------------
        for (int i = 0; i < 3; i++) step(1, c_CTX, 0, 1, 32'(8'h31 + i), 0);
        step(1, c_STAT, 1, 0, 32'd0, 0);
        chk("queued3_status", 64'(mem_rdata), 64'h0300);
        step(0, c_STAT, 0, 0, 32'd0, 0);
        chk("rst_txv", 64'(tx_valid), 64'd0);
        chk("rst_rdata", 64'(mem_rdata), 64'd0);
        chk("rst_berr", 64'(bus_err), 64'd0);
        chk("rst_thd", 64'(tohost_data), 64'd0);
        step(1, c_STAT, 1, 0, 32'd0, 0);
        chk("rst_status", 64'(mem_rdata), 64'h1);

        // ---------------- cycle counter ----------------
        step(0, 32'd0, 0, 0, 32'd0, 0);
        repeat (100) step(1, 32'd0, 0, 0, 32'd0, 0);
        step(1, c_CLO, 1, 0, 32'd0, 0);
        v = mem_rdata;
        chk("cycle_lo_range", 64'(v >= 32'd100 && v <= 32'd102), 64'd1);
        step(1, c_CHI, 1, 0, 32'd0, 0);
        chk("cycle_hi", 64'(mem_rdata), 64'd0);

        // ---------------- randomized traffic vs model ----------------
        step(0, 32'd0, 0, 0, 32'd0, 0);
        for (int i = 0; i < 16; i++) step(1, 32'(i * 4), 0, 1, $urandom, 0);
        step(1, 32'((RAM_WORDS - 1) * 4), 0, 1, $urandom, 0);
        for (int i = 0; i < 1500; i++) begin
            int unsigned op = $urandom_range(0, 3);
            a   = rand_addr();
            r   = (op == 1 || op == 3);
            w   = (op == 2 || op == 3);
            rdy = ((i % 400) < 200) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
            rn  = 1'b1;
            if ($urandom_range(0, 249) == 0) begin
                rn = 1'b0;
                w  = 1'b0;
            end
            step(rn, a, r, w, $urandom, rdy);
            chk("rnd_rdata", 64'(mem_rdata), 64'(m_rd));
            chk("rnd_txv", 64'(tx_valid), 64'(m_q.size() != 0));
            if (m_q.size() != 0) chk("rnd_txd", 64'(tx_data), 64'(m_q[0]));
            chk("rnd_thv", 64'(tohost_valid), 64'(m_thv));
            chk("rnd_thd", 64'(tohost_data), 64'(m_thd));
            chk("rnd_berr", 64'(bus_err), 64'(m_berr));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
